mc_control: RTL and testbench

- Multi-cycle control sequencer for the simple MIPS32 core; replaces the single-cycle decoder with an FSM.
- Steps each instruction through fetch / decode / execute / memory / write-back.
- Drives the shared datapath: one memory port, one ALU, PC, IR and register file.
- Stalls on a memory ready handshake.
- Opcode encodings come from MIPS_Parameters.vh (`OP_BEQ, `OP_J, `OP_SW, `OP_LW, `OP_ADD, `OP_SUB, `OP_OR, `OP_AND, `OP_ADDI).

---
 rtl/mc_control.sv | 204 ++++++++++++++++++++
 tb/tb_mc_control.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// Multi-cycle MIPS32 control sequencer: steps each instruction through fetch/decode/execute/memory/write-back.
// Optional MC_CONTROL_PERF_EN adds cycle and retired-instruction counters.
module mc_control #(
  parameter int INSTR_W = 16,
  parameter int OP_MSB  = 15,
  parameter int OP_LSB  = 10
`ifdef MC_CONTROL_PERF_EN
  ,
  parameter int CNT_W   = 32
`endif
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [INSTR_W-1:0] i_instrCode,
  input  logic               i_memReady,
  output logic               o_pcWrite,
  output logic               o_pcWriteCond,
  output logic [1:0]         o_pcSrc,
  output logic               o_irWrite,
  output logic               o_memRead,
  output logic               o_memWrite,
  output logic               o_iOrD,
  output logic               o_aluSrcA,
  output logic [1:0]         o_aluSrcB,
  output logic [1:0]         o_aluOp,
  output logic               o_regDst,
  output logic               o_memToReg,
  output logic               o_regWrite,
  output logic               o_illegal,
  output logic [3:0]         o_state
`ifdef MC_CONTROL_PERF_EN
  ,
  output logic [CNT_W-1:0]   o_cycleCnt,
  output logic [CNT_W-1:0]   o_instrCnt
`endif
);

  localparam int OP_W = OP_MSB - OP_LSB + 1;

  // Opcode encodings, kept in step with MIPS_Parameters.vh
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(6'h00);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(6'h01);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(6'h02);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(6'h03);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'h04);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'h05);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'h06);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'h07);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'h08);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADDR = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWR   = 4'd5,
    S_WB_MEM  = 4'd6,
    S_EXEC_R  = 4'd7,
    S_EXEC_I  = 4'd8,
    S_WB_ALU  = 4'd9,
    S_WB_ALUI = 4'd10,
    S_BRANCH  = 4'd11,
    S_JUMP    = 4'd12,
    S_TRAP    = 4'd15
  } state_e;

  state_e              state_q, state_d;
  logic [OP_W-1:0]     op_q;
  logic [OP_W-1:0]     op_in;
  logic                unused_instr;

  assign op_in        = i_instrCode[OP_MSB:OP_LSB];
  assign unused_instr = ^i_instrCode;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= op_in;
    end
  end

  always_comb begin
    state_d       = state_q;
    o_pcWrite     = 1'b0;
    o_pcWriteCond = 1'b0;
    o_pcSrc       = 2'b00;
    o_irWrite     = 1'b0;
    o_memRead     = 1'b0;
    o_memWrite    = 1'b0;
    o_iOrD        = 1'b0;
    o_aluSrcA     = 1'b0;
    o_aluSrcB     = 2'b00;
    o_aluOp       = 2'b00;
    o_regDst      = 1'b0;
    o_memToReg    = 1'b0;
    o_regWrite    = 1'b0;
    o_illegal     = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        o_memRead = 1'b1;
        o_aluSrcB = 2'b01;
        if (i_memReady) begin
          o_irWrite = 1'b1;
          o_pcWrite = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        // IR was loaded on the fetch edge, so the live opcode is valid here only
        o_aluSrcB = 2'b11;
        if (op_in == OP_LW || op_in == OP_SW) state_d = S_MEMADDR;
        else if (op_in == OP_ADD || op_in == OP_SUB || op_in == OP_OR || op_in == OP_AND)
          state_d = S_EXEC_R;
        else if (op_in == OP_ADDI) state_d = S_EXEC_I;
        else if (op_in == OP_BEQ)  state_d = S_BRANCH;
        else if (op_in == OP_J)    state_d = S_JUMP;
        else                       state_d = S_TRAP;
      end
      S_MEMADDR: begin
        o_aluSrcA = 1'b1;
        o_aluSrcB = 2'b10;
        state_d   = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        o_memRead = 1'b1;
        o_iOrD    = 1'b1;
        if (i_memReady) state_d = S_WB_MEM;
      end
      S_MEMWR: begin
        o_memWrite = 1'b1;
        o_iOrD     = 1'b1;
        if (i_memReady) state_d = S_FETCH;
      end
      S_WB_MEM: begin
        o_regWrite = 1'b1;
        o_memToReg = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXEC_R: begin
        o_aluSrcA = 1'b1;
        o_aluOp   = 2'b10;
        state_d   = S_WB_ALU;
      end
      S_EXEC_I: begin
        o_aluSrcA = 1'b1;
        o_aluSrcB = 2'b10;
        state_d   = S_WB_ALUI;
      end
      S_WB_ALU: begin
        o_regWrite = 1'b1;
        o_regDst   = 1'b1;
        state_d    = S_FETCH;
      end
      S_WB_ALUI: begin
        o_regWrite = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        o_aluSrcA     = 1'b1;
        o_aluOp       = 2'b01;
        o_pcWriteCond = 1'b1;
        o_pcSrc       = 2'b01;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        o_pcWrite = 1'b1;
        o_pcSrc   = 2'b10;
        state_d   = S_FETCH;
      end
      S_TRAP:  o_illegal = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  assign o_state = state_q;

`ifdef MC_CONTROL_PERF_EN
  logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q;
  logic             retire;

  assign retire = (state_d == S_FETCH) &&
                  (state_q == S_WB_MEM || state_q == S_MEMWR || state_q == S_WB_ALU ||
                   state_q == S_WB_ALUI || state_q == S_BRANCH || state_q == S_JUMP);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      if (state_q != S_IDLE && state_q != S_TRAP) cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      if (retire) instr_cnt_q <= instr_cnt_q + CNT_W'(1);
    end
  end

  assign o_cycleCnt = cycle_cnt_q;
  assign o_instrCnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_mc_control.sv
// Randomized bench for mc_control: each instruction is expanded into its expected per-cycle
// state trace (with random memory wait counts) and every cycle's outputs are compared.
module tb_mc_control;

  localparam logic [5:0] OP_ADD = 6'h00, OP_SUB = 6'h01, OP_OR = 6'h02, OP_AND = 6'h03,
                         OP_ADDI = 6'h04, OP_LW = 6'h05, OP_SW = 6'h06, OP_BEQ = 6'h07,
                         OP_J = 6'h08, OP_ILL = 6'h3F;

  logic        clk, rst_n, mem_ready;
  logic [15:0] instr;
  logic        pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d, alu_src_a;
  logic        reg_dst, mem_to_reg, reg_write, illegal;
  logic [1:0]  pc_src, alu_src_b, alu_op;
  logic [3:0]  state;
  logic [16:0] obs;
`ifdef MC_CONTROL_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  mc_control dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_instrCode(instr), .i_memReady(mem_ready),
    .o_pcWrite(pc_write), .o_pcWriteCond(pc_write_cond), .o_pcSrc(pc_src),
    .o_irWrite(ir_write), .o_memRead(mem_read), .o_memWrite(mem_write), .o_iOrD(i_or_d),
    .o_aluSrcA(alu_src_a), .o_aluSrcB(alu_src_b), .o_aluOp(alu_op), .o_regDst(reg_dst),
    .o_memToReg(mem_to_reg), .o_regWrite(reg_write), .o_illegal(illegal), .o_state(state)
`ifdef MC_CONTROL_PERF_EN
    , .o_cycleCnt(cycle_cnt), .o_instrCnt(instr_cnt)
`endif
  );

  assign obs = {pc_write, pc_write_cond, pc_src, ir_write, mem_read, mem_write, i_or_d,
                alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int exp_st[$];
  bit exp_rdy[$];
  int dec_idx;
  int cyc_m, instr_m;

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // Expected strobe vector for a state code, straight from the per-state table
  function automatic logic [16:0] exp_out(input int st, input bit rdy);
    logic pw = 0, pwc = 0, irw = 0, mr = 0, mw = 0, iod = 0, asa = 0, rd = 0, m2r = 0, rw = 0, ill = 0;
    logic [1:0] ps = 0, asb = 0, aop = 0;
    case (st)
      1:  begin mr = 1; asb = 2'b01; if (rdy) begin irw = 1; pw = 1; end end
      2:  asb = 2'b11;
      3:  begin asa = 1; asb = 2'b10; end
      4:  begin mr = 1; iod = 1; end
      5:  begin mw = 1; iod = 1; end
      6:  begin rw = 1; m2r = 1; end
      7:  begin asa = 1; aop = 2'b10; end
      8:  begin asa = 1; asb = 2'b10; end
      9:  begin rw = 1; rd = 1; end
      10: rw = 1;
      11: begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; end
      12: begin pw = 1; ps = 2'b10; end
      15: ill = 1;
      default: ;
    endcase
    return {pw, pwc, ps, irw, mr, mw, iod, asa, asb, aop, rd, m2r, rw, ill};
  endfunction

  task automatic push(input int st);
    exp_st.push_back(st);
    exp_rdy.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic push_wait(input int st, input int w);
    for (int i = 0; i < w; i++) begin exp_st.push_back(st); exp_rdy.push_back(1'b0); end
    exp_st.push_back(st);
    exp_rdy.push_back(1'b1);
  endtask

  task automatic build(input logic [5:0] op, input int wf, input int wm);
    exp_st.delete();
    exp_rdy.delete();
    push_wait(1, wf);
    dec_idx = exp_st.size();
    push(2);
    case (op)
      OP_ADD, OP_SUB, OP_OR, OP_AND: begin push(7); push(9); end
      OP_ADDI: begin push(8); push(10); end
      OP_LW:   begin push(3); push_wait(4, wm); push(6); end
      OP_SW:   begin push(3); push_wait(5, wm); end
      OP_BEQ:  push(11);
      OP_J:    push(12);
      default: for (int i = 0; i < 12; i++) push(15);
    endcase
  endtask

  task automatic check_cnt(input string tag);
`ifdef MC_CONTROL_PERF_EN
    check({tag, " cycleCnt"}, cycle_cnt, cyc_m);
    check({tag, " instrCnt"}, instr_cnt, instr_m);
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // Runs a built trace; stops at negedge before index stop_at when stop_at >= 0
  task automatic run(input logic [5:0] op, input int stop_at);
    for (int k = 0; k < exp_st.size(); k++) begin
      if (k == stop_at) return;
      mem_ready = exp_rdy[k];
      instr = (k <= dec_idx) ? {op, 10'($urandom)} : 16'($urandom);
      #1;
      check($sformatf("op%0h k%0d state", op, k), 32'(state), 32'(exp_st[k]));
      check($sformatf("op%0h k%0d outs", op, k), 32'(obs), 32'(exp_out(exp_st[k], exp_rdy[k])));
      check_cnt($sformatf("op%0h k%0d", op, k));
      if (exp_st[k] != 0 && exp_st[k] != 15) cyc_m++;
      @(posedge clk);
      @(negedge clk);
    end
    if (op != OP_ILL) instr_m++;
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    #1;
    check("idle state", 32'(state), 0);
    check("idle outs", 32'(obs), 0);
    check_cnt("idle");
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic assert_reset_async(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, " state"}, 32'(state), 0);
    check({tag, " outs"}, 32'(obs), 0);
    cyc_m = 0;
    instr_m = 0;
    check_cnt(tag);
    @(posedge clk);
    @(negedge clk);
    check({tag, " held"}, 32'(obs), 0);
  endtask

  initial begin
    logic [5:0] legal [9];
    legal = '{OP_ADD, OP_SUB, OP_OR, OP_AND, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J};
    rst_n = 1'b0; mem_ready = 1'b1; instr = '0; cyc_m = 0; instr_m = 0;
    repeat (2) @(negedge clk);
    #1;
    check("reset state", 32'(state), 0);
    check("reset outs", 32'(obs), 0);
    @(negedge clk);
    release_reset();

    build(OP_ADD, 0, 0); run(OP_ADD, -1);
    build(OP_LW, 0, 3);  run(OP_LW, -1);
    build(OP_SW, 0, 0);  run(OP_SW, -1);
    build(OP_BEQ, 0, 0); run(OP_BEQ, -1);
    build(OP_J, 0, 0);   run(OP_J, -1);

    for (int n = 0; n < 40; n++) begin
      logic [5:0] op;
      op = legal[$urandom_range(0, 8)];
      build(op, $urandom_range(0, 3), $urandom_range(0, 3));
      run(op, -1);
    end

    build(OP_ILL, 1, 0); run(OP_ILL, -1);
    check("trap sticky", 32'(illegal), 1);
    assert_reset_async("trap clear");
    release_reset();

    build(OP_LW, 0, 3); run(OP_LW, 4);
    check("in memrd", 32'(state), 4);
    mem_ready = 1'b1;
    assert_reset_async("memrd abort");
    release_reset();
    build(OP_ADD, 0, 0); run(OP_ADD, -1);
    build(OP_ADD, 0, 0); run(OP_ADD, -1);
    mem_ready = 1'b1;
    #1;
    check("after adds fetch", 32'(state), 1);
`ifdef MC_CONTROL_PERF_EN
    check("two adds instrCnt", instr_cnt, 2);
    check("two adds cycleCnt", cycle_cnt, 8);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
